// File: rtl/mac_out_stage_pkg.sv
// rtl/mac_out_stage_pkg.sv - shared accumulator type and limits for the MAC output stage
package mac_out_stage_pkg;

    typedef logic signed [15:0] acc_t;

    localparam acc_t ACC_MAX   = 16'sh7FFF;
    localparam acc_t ACC_MIN   = 16'sh8000;
    localparam int   OUT_DEPTH = 4;

endpackage

// File: rtl/mac_out_stage_sync_fifo.sv
// rtl/mac_out_stage_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module nnp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [AW:0] w_diff;
    logic        w_pop;
    logic        w_push;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign w_diff  = r_wr_ptr - r_rd_ptr;
    assign empty   = (w_diff == '0);
    assign full    = (w_diff == FULL_CNT);
    assign w_pop   = pop && !empty;
    assign w_push  = push && (!full || w_pop);
    assign count   = CW'(w_diff);
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_out_stage.sv
// rtl/mac_out_stage.sv - saturate/ReLU MAC results and buffer them for the writeback port
module mac_out_stage
    import mac_out_stage_pkg::*;
#(
    parameter int DEPTH   = OUT_DEPTH,
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                mac_f,
    input  logic                       mac_valid,
    input  logic                       mac_overflow,
    output logic [15:0]                m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_err,
    output logic [CNT_W-1:0]           sat_cnt
);

    acc_t             r_s_data;
    logic             r_s_valid;
    logic             r_drop_err;
    logic [CNT_W-1:0] r_sat_cnt;

    acc_t w_sat;
    acc_t w_val;
    logic w_full;
    logic w_empty;
    logic w_pop;

    // An overflowed accumulator has wrapped, so its true sign is the opposite of bit 15.
    always_comb begin
        w_sat = acc_t'(mac_f);
        if (mac_overflow) begin
            w_sat = mac_f[15] ? ACC_MAX : ACC_MIN;
        end
        w_val = w_sat;
        if ((RELU_EN != 0) && w_sat[15]) begin
            w_val = '0;
        end
    end

    assign m_valid  = !w_empty;
    assign w_pop    = m_valid && m_ready;
    assign drop_err = r_drop_err;
    assign sat_cnt  = r_sat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_data   <= '0;
            r_s_valid  <= 1'b0;
            r_drop_err <= 1'b0;
            r_sat_cnt  <= '0;
        end else begin
            r_s_valid <= mac_valid;
            if (mac_valid) begin
                r_s_data <= w_val;
            end
            if (mac_valid && mac_overflow && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end
            // The MAC cannot be stalled, so a result arriving at a full FIFO is lost.
            if (r_s_valid && w_full && !w_pop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    nnp_sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (r_s_valid),
        .wr_data (r_s_data),
        .pop     (w_pop),
        .rd_data (m_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

endmodule
